round_robin_arbiter: RTL and testbench
======================================

Name: round_robin_arbiter

Overview:
- Parameterised N-way round-robin arbiter with a registered one-hot grant output.
- Each clock it grants one active requester, starting the search at the index just after the previous winner, so continuously requesting agents are served fairly in rotation.
- Used wherever several agents share one resource (bus, port, memory bank).

Parameters:
- requesters, default 4: number of request lines and grant lines (N); legal range N >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset = 0 clears state immediately, independent of clk.
- request  input  requesters  request vector; bit i = 1 means requester i wants the resource this cycle.
- chosen  output  requesters  registered one-hot grant; bit i = 1 means requester i is granted this cycle; all zero means no grant.

Behaviour:
- State:
  - chosen register, N bits.
  - Priority pointer ptr, width clog2(N) with minimum 1, holding the highest-priority index for the next arbitration.
- Reset:
  - While reset = 0: chosen = 0 and ptr = 0, asynchronously.
  - Reset asserted mid-operation clears chosen on the same delta, without waiting for an edge.
  - After release, the first arbitration starts from index 0.
- Arbitration on each rising clk edge with reset = 1:
  - Search request starting at index ptr, then ptr+1, ptr+2, and so on, wrapping modulo N, and stop at the first set bit k.
  - chosen <= one-hot(k).
  - ptr <= (k+1) mod N.
- No requests (request = 0): chosen <= 0 and ptr is held unchanged.
- Latency:
  - One clock from request to grant; chosen reflects the request vector sampled at the previous edge.
  - Combinational changes on request between edges do not affect chosen.
- No handshake or hold:
  - A grant lasts exactly one cycle.
  - A requester that keeps its bit high gets re-granted only when its turn comes around again.
  - Dropping a request simply removes it from the next search.
- Wrap-around:
  - If ptr = N-1 and bit N-1 is clear, the search continues at index 0.
  - If the only requester is the previous winner, it is granted again (the search wraps fully back to it).
- Output is always one-hot or zero; never more than one bit set.
- N = 1: chosen <= request each edge, and ptr stays 0.
- request is assumed synchronous to clk; no internal synchronisers.

Test Plan (N = 4):
1. Reset: hold reset = 0 with request = 1111 over several edges -> chosen = 0000 throughout; release -> first edge with 1111 gives 0001.
2. Rotation under full load: after reset, request = 1111 held -> chosen sequence 0001, 0010, 0100, 1000, 0001 on successive edges.
3. Sparse requests: after reset, request = 0101 held -> 0001, 0100, 0001, 0100; then request = 1010 held -> 1000, 0010, 1000 (next edge after last 0100 grants 1000, since ptr = 3).
4. Idle preserves pointer: grant 0010 (ptr = 2), then request = 0000 for 3 edges -> chosen = 0000; then request = 1111 -> 0100.
5. Wrap and single requester: after grant 0100 (ptr = 3), request = 0011 -> 0001. Request = 0100 held -> 0100 every edge.
6. Asynchronous reset mid-operation: while granting under 1111, drive reset = 0 between edges -> chosen = 0000 immediately. Release -> next edge gives 0001.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with a registered one-hot grant.
// The search starts at the index just after the previous winner, so agents that keep requesting are served in turn.
module round_robin_arbiter #(
  parameter int requesters = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [requesters-1:0] request,
  output logic [requesters-1:0] chosen
);

  localparam int pw = (requesters > 1) ? $clog2(requesters) : 1;
  localparam logic [pw-1:0] last_index = pw'(requesters - 1);

  logic [pw-1:0]         ptr;
  logic [pw-1:0]         winner;
  logic [pw-1:0]         next_ptr;
  logic [requesters-1:0] next_grant;
  logic                  found;
  int                    idx;

  // Scan from ptr upward, wrapping modulo N; the first set bit wins.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    next_grant = '0;
    idx        = 0;
    for (int i = 0; i < requesters; i++) begin
      idx = int'(ptr) + i;
      if (idx >= requesters) idx = idx - requesters;
      if (!found && request[idx]) begin
        found           = 1'b1;
        winner          = pw'(idx);
        next_grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr = ptr;
    if (found) next_ptr = (winner == last_index) ? '0 : winner + pw'(1);
  end

  // An idle cycle (no requests) holds ptr so the rotation resumes where it left off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chosen <= '0;
      ptr    <= '0;
    end else begin
      chosen <= next_grant;
      ptr    <= next_ptr;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter (N = 4): plan vectors from a table,
// hand-written asynchronous-reset and latency sequences, then random traffic against a reference model.
module tb_round_robin_arbiter;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] request = '0;
  logic [3:0] chosen;

  vec_t       vecs[$];
  logic [3:0] expected_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         model_ptr;

  round_robin_arbiter #(.requesters(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .request (request),
    .chosen  (chosen)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [3:0] actual, input logic [3:0] want);
    tests_run++;
    if (actual !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: chosen=%b expected=%b", name, actual, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the grant expected after the next rising edge.
  task automatic applyStimulus(input logic rstn, input logic [3:0] req, input logic [3:0] exp);
    @(negedge clk);
    reset   = rstn;
    request = req;
    expected_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    if (expected_q.size() == 0) begin
      compare({name, " (scoreboard empty)"}, chosen, 4'bxxxx);
    end else begin
      compare(name, chosen, expected_q.pop_front());
    end
  endtask

  // Reference behaviour: first set bit searching from model_ptr, wrapping; ptr held when idle.
  function automatic logic [3:0] model_step(input logic [3:0] req);
    logic [3:0] g;
    int         k;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      k = (model_ptr + i) % 4;
      if (req[k]) begin
        g[k]      = 1'b1;
        model_ptr = (k + 1) % 4;
        break;
      end
    end
    return g;
  endfunction

  initial begin
    logic [3:0] held;
    logic [3:0] r;

    // Reset held with full load, then rotation.
    repeat (3) vecs.push_back('{1'b0, 4'b1111, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b0001});
    vecs.push_back('{1'b1, 4'b1111, 4'b0010});
    vecs.push_back('{1'b1, 4'b1111, 4'b0100});
    vecs.push_back('{1'b1, 4'b1111, 4'b1000});
    vecs.push_back('{1'b1, 4'b1111, 4'b0001});
    // Sparse requests from a fresh reset.
    vecs.push_back('{1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 4'b0101, 4'b0001});
    vecs.push_back('{1'b1, 4'b0101, 4'b0100});
    vecs.push_back('{1'b1, 4'b0101, 4'b0001});
    vecs.push_back('{1'b1, 4'b0101, 4'b0100});
    vecs.push_back('{1'b1, 4'b1010, 4'b1000});
    vecs.push_back('{1'b1, 4'b1010, 4'b0010});
    vecs.push_back('{1'b1, 4'b1010, 4'b1000});
    // Idle keeps the pointer (ptr = 2 after granting 0010).
    vecs.push_back('{1'b1, 4'b0010, 4'b0010});
    repeat (3) vecs.push_back('{1'b1, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b0100});
    // Wrap from ptr = 3 and a lone repeat requester.
    vecs.push_back('{1'b1, 4'b0011, 4'b0001});
    repeat (3) vecs.push_back('{1'b1, 4'b0100, 4'b0100});

    #1;
    compare("reset_initial", chosen, 4'b0000);

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].rstn, vecs[v].req, vecs[v].exp);
      checkOutput($sformatf("vec%0d", v));
    end

    // Request changes between edges must not disturb the registered grant.
    applyStimulus(1'b1, 4'b1111, 4'b1000);
    checkOutput("full_load_after_ptr3");
    held = chosen;
    request = 4'b0010;
    #2;
    compare("mid_cycle_request_change", chosen, 4'b1000);
    request = 4'b1111;

    // Asynchronous reset between edges clears the grant without a clock edge.
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    compare("async_reset_immediate", chosen, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkOutput("async_reset_held");
    applyStimulus(1'b1, 4'b1111, 4'b0001);
    checkOutput("after_async_reset_release");
    applyStimulus(1'b1, 4'b1111, 4'b0010);
    checkOutput("after_async_reset_second");

    // Random traffic from a clean reset, scored against the reference model.
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("random_phase_reset");
    model_ptr = 0;
    for (int n = 0; n < 40; n++) begin
      r = 4'($urandom_range(0, 15));
      applyStimulus(1'b1, r, model_step(r));
      checkOutput($sformatf("random%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: chosen=%b expected=finish", chosen);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
